// File: rtl/msdf_test_sequencer.sv
// Avalon-MM controlled read/write address sweeper for the MSDF adder test harness.
// Define MSDF_SEQ_CYCLE_COUNT_EN to add the saturating busy-cycle counter at register 6.

module msdf_test_sequencer #(
    parameter int ID      = 1,
    parameter int ADDR_W  = 11,
    parameter int NUM_CH  = 2,
    parameter int LATENCY = 2
) (
    input  logic              avalon_clock,
    input  logic              resetn,
    input  logic [2:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [NUM_CH-1:0] we,
    output logic              busy
);
    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                       state;
    logic [ADDR_W-1:0]            start_r;
    logic [ADDR_W:0]              end_r;
    logic [ADDR_W:0]              cnt;
    logic [ADDR_W:0]              cnt_inc;
    logic [NUM_CH-1:0]            mask_r;
    logic [NUM_CH-1:0]            mask_lat;
    logic [7:0]                   rep_r;
    logic [7:0]                   pass_left;
    logic [DW-1:0]                drain_cnt;
    logic                         done_r;
    logic [LATENCY:0]             vld_pipe;
    logic [LATENCY:0][ADDR_W-1:0] apipe;
    logic [31:0]                  cycles_rd;

    logic              ctrl_wr;
    logic              abort_req;
    logic              go_acc;
    logic              cfg_wr;
    logic              start_lt_end;
    logic              at_last;
    logic              issue_vld;
    logic [ADDR_W-1:0] issue_addr;
    logic              unused_wd;

    assign busy         = (state != S_IDLE);
    assign ctrl_wr      = write && (address == 3'd0);
    assign abort_req    = ctrl_wr && writedata[1];
    assign go_acc       = ctrl_wr && writedata[0] && !writedata[1] && !busy;
    assign cfg_wr       = write && !busy;
    assign start_lt_end = ({1'b0, start_r} < end_r);
    assign cnt_inc      = cnt + (ADDR_W+1)'(1);
    assign at_last      = (cnt == end_r - (ADDR_W+1)'(1));
    assign unused_wd    = ^writedata;

    // Address launched into the pipeline on this edge; a new pass restarts with no bubble.
    always_comb begin
        issue_vld  = 1'b0;
        issue_addr = start_r;
        case (state)
            S_IDLE: issue_vld = go_acc && start_lt_end;
            S_RUN: begin
                if (!abort_req) begin
                    if (!at_last) begin
                        issue_vld  = 1'b1;
                        issue_addr = cnt_inc[ADDR_W-1:0];
                    end else if (pass_left > 8'd1) begin
                        issue_vld = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pass_left <= '0;
            drain_cnt <= '0;
            done_r    <= 1'b0;
            mask_lat  <= '1;
        end else if (abort_req) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_acc) begin
                        done_r    <= 1'b0;
                        cnt       <= {1'b0, start_r};
                        pass_left <= (rep_r == 8'd0) ? 8'd1 : rep_r;
                        mask_lat  <= mask_r;
                        if (start_lt_end) begin
                            state <= S_RUN;
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= DW'(LATENCY-1);
                        end
                    end
                end
                S_RUN: begin
                    if (at_last) begin
                        if (pass_left > 8'd1) begin
                            pass_left <= pass_left - 8'd1;
                            cnt       <= {1'b0, start_r};
                        end else begin
                            state     <= S_DRAIN;
                            drain_cnt <= DW'(LATENCY-1);
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            apipe    <= '0;
            r_addr   <= '0;
        end else begin
            if (abort_req) vld_pipe <= '0;
            else           vld_pipe <= {vld_pipe[LATENCY-1:0], issue_vld};
            apipe <= {apipe[LATENCY-1:0], issue_addr};
            if (issue_vld) r_addr <= issue_addr;
        end
    end

    assign w_addr = apipe[LATENCY];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign we[i] = vld_pipe[LATENCY] & mask_lat[i];
    end

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            start_r <= '0;
            end_r   <= '0;
            mask_r  <= '1;
            rep_r   <= '0;
        end else if (cfg_wr) begin
            case (address)
                3'd1:    start_r <= writedata[ADDR_W-1:0];
                3'd2:    end_r   <= writedata[ADDR_W:0];
                3'd4:    mask_r  <= writedata[NUM_CH-1:0];
                3'd5:    rep_r   <= writedata[7:0];
                default: ;
            endcase
        end
    end

`ifdef MSDF_SEQ_CYCLE_COUNT_EN
    logic [31:0] cycles;

    // Cleared at GO; the abort edge itself is not counted so the value freezes there.
    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn)                                   cycles <= '0;
        else if (go_acc)                               cycles <= '0;
        else if (busy && !abort_req && cycles != '1)   cycles <= cycles + 32'd1;
    end
    assign cycles_rd = cycles;
`else
    assign cycles_rd = '0;
`endif

    always_ff @(posedge avalon_clock or negedge resetn) begin
        if (!resetn) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                3'd0:    readdata <= {30'd0, done_r, busy};
                3'd1:    readdata <= 32'(start_r);
                3'd2:    readdata <= 32'(end_r);
                3'd3:    readdata <= 32'(ID);
                3'd4:    readdata <= 32'(mask_r);
                3'd5:    readdata <= {24'd0, rep_r};
                3'd6:    readdata <= cycles_rd;
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_msdf_test_sequencer.sv
// Bench for msdf_test_sequencer: Avalon traffic drives a transaction-level model that queues
// expected r_addr / we / readdata events by clock edge; an independent monitor checks them.
`timescale 1ns/1ps
module tb_msdf_test_sequencer;
    localparam int AW    = 4;
    localparam int NC    = 2;
    localparam int LAT   = 2;
    localparam int IDV   = 5;
    localparam int NEVER = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [2:0]    address = '0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic          read = 1'b0;
    logic [31:0]   readdata;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr;
    logic [NC-1:0] we;
    logic          busy;

    msdf_test_sequencer #(.ID(IDV), .ADDR_W(AW), .NUM_CH(NC), .LATENCY(LAT)) dut (
        .avalon_clock(clk), .resetn(rstn), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata), .r_addr(r_addr),
        .w_addr(w_addr), .we(we), .busy(busy)
    );

    always #5 clk = ~clk;

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct { int e; logic [AW-1:0] a; logic [NC-1:0] m; } ev_t;
    typedef struct { int e; logic [31:0] v; } rd_t;
    ev_t rq[$];
    ev_t wq[$];
    rd_t dq[$];
    ev_t mev;
    rd_t mrd;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: register file plus the edge windows of the current run.
    logic [AW-1:0] m_start;
    logic [AW:0]   m_end;
    logic [NC-1:0] m_mask;
    logic [7:0]    m_rep;
    int b_lo, b_hi, d_clr_e, d_set_e, go_e, m_cyc;
    bit d_prev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h want %0h", nm, ecount, act, exp);
        end
    endtask

    function automatic bit busy_at(input int x);
        return (x >= b_lo) && (x <= b_hi);
    endfunction

    function automatic bit done_at(input int x);
        if (x >= d_set_e) return 1'b1;
        if (x >= d_clr_e) return 1'b0;
        return d_prev;
    endfunction

    task automatic model_reset();
        m_start = '0; m_end = '0; m_mask = '1; m_rep = '0;
        b_lo = 1; b_hi = 0; d_prev = 1'b0; d_clr_e = NEVER; d_set_e = NEVER;
        go_e = 0; m_cyc = 0;
        rq.delete(); wq.delete(); dq.delete();
    endtask

    task automatic model_go(input int t);
        int p, n;
        logic [AW-1:0] ad;
        p = (m_rep == 8'd0) ? 1 : int'(m_rep);
        n = (int'(m_end) > int'(m_start)) ? int'(m_end) - int'(m_start) : 0;
        d_prev  = done_at(t - 1);
        d_clr_e = t;
        d_set_e = t + p * n + LAT;
        b_lo    = t;
        b_hi    = t + p * n + LAT - 1;
        go_e    = t;
        m_cyc   = p * n + LAT;
        for (int i = 0; i < p * n; i++) begin
            ad = AW'(int'(m_start) + (i % n));
            rq.push_back('{t + i, ad, '0});
            wq.push_back('{t + i + LAT, ad, m_mask});
        end
    endtask

    task automatic model_abort(input int t);
        d_set_e = NEVER;
        b_hi    = t - 1;
        m_cyc   = t - 1 - go_e;
        while (rq.size() > 0 && rq[rq.size()-1].e >= t) void'(rq.pop_back());
        while (wq.size() > 0 && wq[wq.size()-1].e >= t) void'(wq.pop_back());
    endtask

    task automatic model_write(input int t, input int a, input logic [31:0] d);
        bit bz;
        bz = busy_at(t - 1);
        case (a)
            0: begin
                if (d[1]) begin
                    if (bz) model_abort(t);
                end else if (d[0] && !bz) begin
                    model_go(t);
                end
            end
            1: if (!bz) m_start = d[AW-1:0];
            2: if (!bz) m_end   = d[AW:0];
            4: if (!bz) m_mask  = d[NC-1:0];
            5: if (!bz) m_rep   = d[7:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] exp_read(input int x, input int a);
        case (a)
            0: return {30'd0, done_at(x), busy_at(x)};
            1: return 32'(m_start);
            2: return 32'(m_end);
            3: return 32'(IDV);
            4: return 32'(m_mask);
            5: return 32'(m_rep);
            6: begin
`ifdef MSDF_SEQ_CYCLE_COUNT_EN
                return 32'(m_cyc);
`else
                return 32'd0;
`endif
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic wr(input int a, input int d);
        int t;
        @(negedge clk);
        t = ecount + 1;
        address = 3'(a); writedata = 32'(d); write = 1'b1;
        model_write(t, a, 32'(d));
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input int a);
        int t;
        @(negedge clk);
        t = ecount + 1;
        address = 3'(a); read = 1'b1;
        dq.push_back('{t, exp_read(t - 1, a)});
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wait_idle();
        while (ecount < b_hi + 2) @(negedge clk);
    endtask

    task automatic chk_outputs_reset();
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_r_addr", 32'(r_addr), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    // Monitor: compares DUT outputs with whatever the model queued for this edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(busy_at(ecount)));
            while (wq.size() > 0 && wq[0].e < ecount) begin
                mev = wq.pop_front(); checks++; errors++;
                $display("FAIL we_missing edge %0d: no write seen, want addr %0h", mev.e, mev.a);
            end
            if (wq.size() > 0 && wq[0].e == ecount) begin
                mev = wq.pop_front();
                chk("we", 32'(we), 32'(mev.m));
                chk("w_addr", 32'(w_addr), 32'(mev.a));
            end else begin
                chk("we_idle", 32'(we), 32'd0);
            end
            while (rq.size() > 0 && rq[0].e < ecount) begin
                mev = rq.pop_front(); checks++; errors++;
                $display("FAIL r_addr_missing edge %0d: want %0h", mev.e, mev.a);
            end
            if (rq.size() > 0 && rq[0].e == ecount) begin
                mev = rq.pop_front();
                chk("r_addr", 32'(r_addr), 32'(mev.a));
            end
            while (dq.size() > 0 && dq[0].e < ecount) begin
                mrd = dq.pop_front(); checks++; errors++;
                $display("FAIL readdata_missing edge %0d: want %0h", mrd.e, mrd.v);
            end
            if (dq.size() > 0 && dq[0].e == ecount) begin
                mrd = dq.pop_front();
                chk("readdata", readdata, mrd.v);
            end
        end
    end

    initial begin
        int ra;
        model_reset();
        #2;
        chk_outputs_reset();
        repeat (3) @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;
        for (int a = 0; a < 8; a++) rd(a);

        // Single pass 0..3, cycle count 6
        wr(1, 0); wr(2, 4); wr(5, 1); wr(0, 1); wait_idle(); rd(0); rd(6);
        // Three back-to-back passes over 2,3
        wr(1, 2); wr(2, 4); wr(5, 3); wr(0, 1); wait_idle(); rd(0); rd(6);
        // Empty range
        wr(1, 5); wr(2, 5); wr(0, 1); wait_idle(); rd(0);
        // Top of the address space, no wrap
        wr(1, 14); wr(2, 16); wr(5, 1); wr(0, 1); wait_idle(); rd(2);
        // Channel mask, config writes while busy are dropped
        wr(4, 2); wr(1, 0); wr(2, 6); wr(0, 1); wr(4, 1); wr(1, 9); wait_idle();
        rd(4); rd(1); wr(0, 1); wait_idle();
        // Abort during the third address, then a normal run
        wr(4, 3); wr(1, 0); wr(2, 16); wr(5, 4); wr(0, 1); @(negedge clk); wr(0, 2);
        wait_idle(); rd(0); rd(6);
        wr(5, 1); wr(2, 3); wr(0, 1); wait_idle(); rd(0);
        // GO+ABORT together does nothing; repeated GO while busy is ignored
        wr(0, 3); repeat (4) @(negedge clk); rd(0);
        wr(2, 8); wr(1, 1); wr(0, 1); wr(0, 1); wr(0, 1); wait_idle(); rd(0);

        for (int it = 0; it < 25; it++) begin
            wr(1, int'($urandom_range(0, 15)));
            wr(2, int'($urandom_range(0, 16)));
            wr(5, int'($urandom_range(0, 3)));
            wr(4, int'($urandom_range(0, 3)));
            wr(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                wr(0, 2);
            end else begin
                ra = int'($urandom_range(0, 7));
                if (ra == 6) ra = 7;
                rd(ra);
                wr(1, int'($urandom_range(0, 15)));
            end
            wait_idle(); rd(0); rd(6);
        end

        // Asynchronous reset in the middle of a run
        wr(1, 0); wr(2, 16); wr(5, 2); wr(0, 1);
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        #2 rstn = 1'b0;
        #1 chk_outputs_reset();
        model_reset();
        @(negedge clk);
        rstn   = 1'b1;
        mon_en = 1'b1;
        for (int a = 0; a < 6; a++) rd(a);
        wr(1, 3); wr(2, 7); wr(0, 1); wait_idle(); rd(0);

        repeat (4) @(negedge clk);
        chk("wq_left", 32'(wq.size()), 32'd0);
        chk("rq_left", 32'(rq.size()), 32'd0);
        chk("dq_left", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msdf_test_sequencer.md
# msdf_test_sequencer

Parametrised Avalon-MM controlled test sequencer for the MSDF adder test harness. Sweeps a read address over the operand RAMs of up to `NUM_CH` datapath channels and generates matching result-RAM write enables and addresses, delayed by the datapath latency. It is the single-clock successor of the earlier per-edge test controller: it adds multi-pass repeat, a per-channel enable mask, abort and sticky status. It sits between the HPS Avalon bridge and the operand/result RAM ports.

## Interface
Parameters:
- `ID`, 1 — value returned by the ID register.
- `ADDR_W`, 11 — RAM address width; legal range 4..16.
- `NUM_CH`, 2 — number of datapath channels; legal range 1..8.
- `LATENCY`, 2 — cycles from read address to write of its result; must be at least 1.

Ports (clock and reset first):
- `avalon_clock` in 1 — single clock for the whole block.
- `resetn` in 1 — asynchronous, active-low reset.
- `address` in 3 — register select.
- `write` in 1 — Avalon write strobe.
- `writedata` in 32 — Avalon write data.
- `read` in 1 — Avalon read strobe.
- `readdata` out 32 — read data, registered, 1-cycle read latency.
- `r_addr` out ADDR_W — operand RAM read address, shared by all channels.
- `w_addr` out ADDR_W — result RAM write address.
- `we` out NUM_CH — per-channel result write enable.
- `busy` out 1 — state is not IDLE.

## Operation
Register map (read values are zero-extended):
- 0 CTRL. Write: bit0 GO, bit1 ABORT. Read: bit0 busy, bit1 done (sticky).
- 1 START: `ADDR_W` bits.
- 2 END: exclusive end, `ADDR_W+1` bits, so the full depth 2^ADDR_W can be swept.
- 3 ID: read only.
- 4 CH_MASK: `NUM_CH` bits; reset value is all ones.
- 5 REPEAT: 8 bits; 0 is treated as 1.
- 6 CYCLES: read only (see Configuration).
- Unmapped addresses read 0; writes to them are ignored.

Register writes:
- START, END, CH_MASK and REPEAT are ignored while busy.

FSM states IDLE, RUN, DRAIN:
- **IDLE:** GO clears done, loads the internal counter `cnt` (width `ADDR_W+1`) with START, loads the pass counter, and goes to RUN. If START ≥ END, the block goes straight to DRAIN and issues no valid addresses.
- **RUN:** each cycle `r_addr` = `cnt` and a valid bit enters a `LATENCY`-deep shift pipeline together with `cnt`. `cnt` increments. When `cnt` = END−1 is issued:
  - if passes remain, `cnt` reloads START on the next cycle with no bubble;
  - otherwise the block goes to DRAIN.
- **DRAIN:** lasts exactly `LATENCY` cycles with no new valid bits, then sets done and returns to IDLE.

Outputs:
- `we[i]` = pipeline valid output & CH_MASK[i]. CH_MASK is latched at GO.
- `w_addr` = pipeline address output.

GO and ABORT:
- GO while busy is ignored.
- ABORT in any state clears the pipeline valid bits on the next edge, so `we` is 0 from the following cycle. The FSM returns to IDLE and done is not set.
- GO and ABORT written in the same write: ABORT wins.

Reset values:
- `readdata` = 0, `r_addr` = 0, `w_addr` = 0, `we` = 0, `busy` = 0.
- Registers: START 0, END 0, CH_MASK all ones, REPEAT 0, done 0.

## Timing
- GO write sampled at edge T → `busy` = 1 and `r_addr` = START from T+1.
- Address k of a pass appears at T+1+k. Its `we`/`w_addr` appear at T+1+k+`LATENCY`.
- Total busy cycles = passes × (END−START) + `LATENCY`.
- `readdata` is valid on the cycle after `read`.
- A CTRL read at the cycle done sets returns the pre-update value.
- Reset mid-operation: all outputs reach their reset values immediately (asynchronous reset).
- `r_addr` holds its last value in IDLE and DRAIN.

## Configuration
- `MSDF_SEQ_CYCLE_COUNT_EN` defined: a 32-bit saturating counter clears at GO, increments every busy cycle and freezes at done or abort. It is readable at address 6.
- `MSDF_SEQ_CYCLE_COUNT_EN` undefined: address 6 reads 0 and no counter logic exists.

## Test plan
- START=0, END=4, REPEAT=1, LATENCY=2, GO → `r_addr` 0,1,2,3 on cycles T+1..T+4; `we`=2'b11 with `w_addr` 0..3 on T+3..T+6; done=1; CYCLES=6.
- START=2, END=4, REPEAT=3 → `r_addr` 2,3,2,3,2,3 back to back; 6 writes; busy for 8 cycles.
- START=5, END=5, GO → no `we` pulses; done after `LATENCY` cycles.
- ADDR_W=4, START=14, END=16 → `r_addr` 14,15 and no wrap to 0; `w_addr` 14,15.
- CH_MASK=2'b10 → only `we[1]` pulses. Writing CH_MASK=2'b01 while busy leaves CH_MASK unchanged.
- ABORT written at the 3rd address of END=100 → `we` = 0 from the next cycle; busy=0; done=0. A following GO runs normally.
